// File: rtl/excp_ctrl_pkg.sv
// Shared types and constants for the exception/return sequencer.
package excp_ctrl_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DRAIN_W     = 4;
  localparam int unsigned COUNT_W_DEF = 16;

  // Sequencer states: normal issue, pipeline drain, fetch redirect handshake.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  // Flush masks, bit order {MEM, EXE, DEC}.
  localparam logic [2:0] FLUSH_NONE     = 3'b000;
  localparam logic [2:0] FLUSH_ALL      = 3'b111;
  localparam logic [2:0] FLUSH_EXE_UP   = 3'b011;
  localparam logic [2:0] FLUSH_DEC_ONLY = 3'b001;

  localparam logic [ADDR_W-1:0] DFAULT_VECTOR_DEF = 32'h0000_BEEF;

endpackage

// File: rtl/excp_ctrl.sv
// Exception / ERET sequencer: flushes the pipeline, then redirects fetch to
// the handler vector, the double-fault vector or the saved EPC.
module excp_ctrl
  import excp_ctrl_pkg::*;
#(
  parameter int unsigned       FLUSH_CYCLES  = 2,
  parameter logic [ADDR_W-1:0] DFAULT_VECTOR = DFAULT_VECTOR_DEF,
  parameter int unsigned       COUNT_W       = COUNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_stage_excp,
  input  logic                exe_stage_excp,
  input  logic                mem_stage_excp,
  input  logic                eret,
  input  logic [ADDR_W-1:0]   excp_vector,
  input  logic [ADDR_W-1:0]   epc,
  input  logic                redirect_ack,
  output logic                flush_dec,
  output logic                flush_exe,
  output logic                flush_mem,
  output logic                redirect_valid,
  output logic [ADDR_W-1:0]   redirect_addr,
  output logic                exl,
  output logic                dfault,
  output logic                bad_eret,
  output logic [COUNT_W-1:0]  excp_count
);

  state_e               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [ADDR_W-1:0]    target_q, target_d;
  logic                 exl_q, exl_d;
  logic                 dfault_q, dfault_d;
  logic                 valid_q, valid_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [2:0]           flush;
  logic                 any_excp;

  assign any_excp = dec_stage_excp | exe_stage_excp | mem_stage_excp;

  // State and datapath registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      target_q <= '0;
      exl_q    <= 1'b0;
      dfault_q <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      target_q <= target_d;
      exl_q    <= exl_d;
      dfault_q <= dfault_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  // Next-state, flush decode and bad-ERET detection.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    target_d = target_q;
    exl_d    = exl_q;
    dfault_d = dfault_q;
    valid_d  = valid_q;
    count_d  = count_q;
    flush    = FLUSH_NONE;
    bad_eret = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (any_excp) begin
          // Exception beats a simultaneous ERET; squash offender and younger.
          if (mem_stage_excp)      flush = FLUSH_ALL;
          else if (exe_stage_excp) flush = FLUSH_EXE_UP;
          else                     flush = FLUSH_DEC_ONLY;
          if (exl_q) begin
            target_d = DFAULT_VECTOR;
            dfault_d = 1'b1;
          end else begin
            target_d = excp_vector;
          end
          exl_d   = 1'b1;
          count_d = (count_q == '1) ? count_q : count_q + COUNT_W'(1);
          drain_d = DRAIN_W'(FLUSH_CYCLES);
          state_d = ST_DRAIN;
        end else if (eret) begin
          if (exl_q) begin
            // ERET sits in MEM and retires; only younger stages are squashed.
            flush    = FLUSH_EXE_UP;
            target_d = epc;
            exl_d    = 1'b0;
            drain_d  = DRAIN_W'(FLUSH_CYCLES);
            state_d  = ST_DRAIN;
          end else begin
            bad_eret = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        flush   = FLUSH_ALL;
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q <= DRAIN_W'(1)) begin
          state_d = ST_REDIR;
          valid_d = 1'b1;
        end
      end

      ST_REDIR: begin
        flush = FLUSH_ALL;
        if (redirect_ack) begin
          valid_d = 1'b0;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
    endcase
  end

  assign flush_mem      = flush[2];
  assign flush_exe      = flush[1];
  assign flush_dec      = flush[0];
  assign redirect_valid = valid_q;
  assign redirect_addr  = target_q;
  assign exl            = exl_q;
  assign dfault         = dfault_q;
  assign excp_count     = count_q;

endmodule
